// File: rtl/n8_responder.sv
// ----------------------------------------------------------------------------
// n8_responder
//
// Purpose:
//   The device side of the 8-button serial controller protocol. A poller
//   drives latch/pulse, and this block answers with one button per pulse on
//   an active-low serial line, in A, B, select, start, up, down, left, right
//   order. latch and pulse are asynchronous to clk, so both pass through
//   synchronizers before they reach the FSM. The block also reports when a
//   poll completes.
//
// Optional feature:
//   N8_TURBO_EN (macro) - when defined, the block counts latch rising edges
//   and toggles a turbo phase every TURBO_PERIOD latches. turbo_a and turbo_b
//   then OR that phase into the A and B buttons. When the macro is not
//   defined, turbo_a and turbo_b are ignored.
//
// Parameters:
//   SYNC_STAGES  - synchronizer depth on latch and pulse (minimum 2)
//   TURBO_PERIOD - latch rising edges per turbo phase toggle (1..255)
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   latch      in   poller latch (asynchronous)
//   pulse      in   poller shift clock (asynchronous)
//   buttons    in   [7:0] live buttons, 1 = pressed
//   turbo_a    in   turbo request for A
//   turbo_b    in   turbo request for B
//   data_out   out  serial line, active-low (0 = pressed)
//   bit_cnt    out  [3:0] shifts since latch fell, saturates at 8
//   poll_done  out  one-cycle strobe on the 8th shift
//   poll_count out  [15:0] completed polls, wrapping
// ----------------------------------------------------------------------------
module n8_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int TURBO_PERIOD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        latch,
    input  logic        pulse,
    input  logic [7:0]  buttons,
    input  logic        turbo_a,
    input  logic        turbo_b,
    output logic        data_out,
    output logic [3:0]  bit_cnt,
    output logic        poll_done,
    output logic [15:0] poll_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // Synchronizers, plus one extra flop on each signal for edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] pulse_sync_q;
    logic                   latch_prev_q;
    logic                   pulse_prev_q;
    logic                   latch_s;
    logic                   pulse_s;
    logic                   latch_rise;
    logic                   pulse_rise;

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the pre-edge values, which is what makes the shift
    // chains below behave as chains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            latch_prev_q <= 1'b0;
            pulse_prev_q <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latch};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pulse};
            latch_prev_q <= latch_s;
            pulse_prev_q <= pulse_s;
        end
    end

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev_q;
    assign pulse_rise = pulse_s & ~pulse_prev_q;

    // ------------------------------------------------------------------
    // Effective buttons (turbo on A/B)
    // ------------------------------------------------------------------
    logic [7:0] eff_buttons;

`ifdef N8_TURBO_EN
    logic [7:0] turbo_cnt_q;
    logic       turbo_phase_q;

    // turbo_cnt_q counts latches seen in the current phase. The phase
    // flips on the latch after TURBO_PERIOD latches have completed, so
    // every poll in a phase loads the same phase value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turbo_cnt_q   <= 8'd0;
            turbo_phase_q <= 1'b0;
        end else if (latch_rise) begin
            if (turbo_cnt_q == 8'(TURBO_PERIOD)) begin
                turbo_cnt_q   <= 8'd1;
                turbo_phase_q <= ~turbo_phase_q;
            end else begin
                turbo_cnt_q <= turbo_cnt_q + 8'd1;
            end
        end
    end

    assign eff_buttons = {buttons[7:2],
                          buttons[1] | (turbo_b & turbo_phase_q),
                          buttons[0] | (turbo_a & turbo_phase_q)};
`else
    logic unused_turbo;
    assign unused_turbo = &{1'b0, turbo_a, turbo_b, latch_rise};
    assign eff_buttons  = buttons;
`endif

    // ------------------------------------------------------------------
    // Poll FSM, shift register and counters
    // ------------------------------------------------------------------
    logic [1:0]  state_q,      state_d;
    logic [7:0]  shreg_q,      shreg_d;
    logic [3:0]  bit_cnt_q,    bit_cnt_d;
    logic        poll_done_q,  poll_done_d;
    logic [15:0] poll_count_q, poll_count_d;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        poll_done_d  = 1'b0;
        poll_count_d = poll_count_q;

        if (latch_s) begin
            // Latch wins over everything, including a pulse edge and any
            // partial poll, which is abandoned without being counted.
            state_d   = ST_LOAD;
            shreg_d   = eff_buttons;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_LOAD: state_d = ST_SHIFT;
                ST_SHIFT: begin
                    if (pulse_rise) begin
                        shreg_d   = {1'b1, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            poll_done_d  = 1'b1;
                            poll_count_d = poll_count_q + 16'd1;
                            state_d      = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Over-reads shift in 1s, so the line reads "pressed".
                    if (pulse_rise) begin
                        shreg_d = {1'b1, shreg_q[7:1]};
                    end
                end
                ST_IDLE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= 8'd0;
            bit_cnt_q    <= 4'd0;
            poll_done_q  <= 1'b0;
            poll_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            poll_done_q  <= poll_done_d;
            poll_count_q <= poll_count_d;
        end
    end

    assign data_out   = ~shreg_q[0];
    assign bit_cnt    = bit_cnt_q;
    assign poll_done  = poll_done_q;
    assign poll_count = poll_count_q;

endmodule

// File: tb/tb_n8_responder.sv
// ----------------------------------------------------------------------------
// tb_n8_responder
//
// Purpose:
//   Directed bench for n8_responder. It uses a poller with latch high for 10
//   clocks and pulse phases of 6 clocks, then compares the serial bits,
//   counters and strobes against hand-computed values. The turbo expectations
//   follow whether N8_TURBO_EN is defined.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_n8_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        latch;
    logic        pulse;
    logic [7:0]  buttons;
    logic        turbo_a;
    logic        turbo_b;
    logic        data_out;
    logic [3:0]  bit_cnt;
    logic        poll_done;
    logic [15:0] poll_count;

    int n_cmp     = 0;
    int n_bad     = 0;
    int done_seen = 0;

    n8_responder #(
        .SYNC_STAGES (2),
        .TURBO_PERIOD(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .latch     (latch),
        .pulse     (pulse),
        .buttons   (buttons),
        .turbo_a   (turbo_a),
        .turbo_b   (turbo_b),
        .data_out  (data_out),
        .bit_cnt   (bit_cnt),
        .poll_done (poll_done),
        .poll_count(poll_count)
    );

    always #5 clk = ~clk;

    // Count poll_done strobes on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (poll_done === 1'b1) done_seen++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_latch(input int high_clks);
        latch = 1'b1;
        wait_clks(high_clks);
        latch = 1'b0;
        wait_clks(6);
    endtask

    task automatic do_pulse();
        pulse = 1'b1;
        wait_clks(6);
        pulse = 1'b0;
        wait_clks(6);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        latch   = 1'b0;
        pulse   = 1'b0;
        buttons = 8'h00;
        turbo_a = 1'b0;
        turbo_b = 1'b0;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        n_cmp++; if (data_out !== 1'b1) begin n_bad++; $display("FAIL reset_data_out: got %b expected 1", data_out); end
        n_cmp++; if (bit_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
        n_cmp++; if (poll_done !== 1'b0) begin n_bad++; $display("FAIL reset_poll_done: got %b expected 0", poll_done); end
        n_cmp++; if (poll_count !== 16'd0) begin n_bad++; $display("FAIL reset_poll_count: got %0d expected 0", poll_count); end
    endtask

    task automatic test_single_a();
        logic [7:0] exp_line;
        int d0;
        exp_line = 8'b1111_1110;  // data_out for bits 0..7 of buttons=01
        d0 = done_seen;
        buttons = 8'h01;
        do_latch(10);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (data_out !== exp_line[i]) begin
                n_bad++; $display("FAIL single_a_bit%0d: got %b expected %b", i, data_out, exp_line[i]);
            end
            do_pulse();
        end
        n_cmp++; if (data_out !== 1'b0) begin n_bad++; $display("FAIL single_a_after: got %b expected 0", data_out); end
        n_cmp++; if (bit_cnt !== 4'd8) begin n_bad++; $display("FAIL single_a_bit_cnt: got %0d expected 8", bit_cnt); end
        n_cmp++; if (done_seen - d0 !== 1) begin n_bad++; $display("FAIL single_a_done: got %0d strobes expected 1", done_seen - d0); end
        n_cmp++; if (poll_count !== 16'd1) begin n_bad++; $display("FAIL single_a_count: got %0d expected 1", poll_count); end
    endtask

    task automatic test_a5_overrun();
        logic [7:0] exp_line;
        int d0;
        exp_line = 8'b0101_1010;  // bits 0..7 read 0,1,0,1,1,0,1,0
        d0 = done_seen;
        buttons = 8'hA5;
        do_latch(10);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (data_out !== exp_line[i]) begin
                n_bad++; $display("FAIL a5_bit%0d: got %b expected %b", i, data_out, exp_line[i]);
            end
            do_pulse();
        end
        for (int i = 0; i < 3; i++) begin
            do_pulse();
            n_cmp++;
            if (data_out !== 1'b0) begin n_bad++; $display("FAIL a5_extra%0d: got %b expected 0", i, data_out); end
        end
        n_cmp++; if (bit_cnt !== 4'd8) begin n_bad++; $display("FAIL a5_bit_cnt: got %0d expected 8", bit_cnt); end
        n_cmp++; if (done_seen - d0 !== 1) begin n_bad++; $display("FAIL a5_done: got %0d strobes expected 1", done_seen - d0); end
        n_cmp++; if (poll_count !== 16'd2) begin n_bad++; $display("FAIL a5_count: got %0d expected 2", poll_count); end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_seen;
        buttons = 8'h00;
        do_latch(10);
        for (int i = 0; i < 4; i++) do_pulse();
        n_cmp++; if (bit_cnt !== 4'd4) begin n_bad++; $display("FAIL abort_partial: got %0d expected 4", bit_cnt); end
        buttons = 8'hFF;
        latch   = 1'b1;
        wait_clks(10);
        n_cmp++; if (bit_cnt !== 4'd0) begin n_bad++; $display("FAIL abort_bit_cnt: got %0d expected 0", bit_cnt); end
        n_cmp++; if (data_out !== 1'b0) begin n_bad++; $display("FAIL abort_data_out: got %b expected 0", data_out); end
        latch = 1'b0;
        wait_clks(6);
        n_cmp++; if (poll_count !== 16'd2) begin n_bad++; $display("FAIL abort_count: got %0d expected 2", poll_count); end
        n_cmp++; if (done_seen - d0 !== 0) begin n_bad++; $display("FAIL abort_done: got %0d strobes expected 0", done_seen - d0); end
    endtask

    task automatic test_capture_at_fall();
        logic [7:0] exp_line;
        exp_line = ~8'h3C;  // value present when latch fell
        buttons  = 8'h0F;
        latch    = 1'b1;
        wait_clks(5);
        buttons  = 8'h3C;
        wait_clks(6);
        latch    = 1'b0;
        wait_clks(6);
        buttons  = 8'hFF;   // must not be seen
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (data_out !== exp_line[i]) begin
                n_bad++; $display("FAIL capture_bit%0d: got %b expected %b", i, data_out, exp_line[i]);
            end
            do_pulse();
        end
        n_cmp++; if (poll_count !== 16'd3) begin n_bad++; $display("FAIL capture_count: got %0d expected 3", poll_count); end
    endtask

    task automatic test_reset_mid_poll();
        buttons = 8'h5A;
        do_latch(10);
        for (int i = 0; i < 5; i++) do_pulse();
        n_cmp++; if (bit_cnt !== 4'd5) begin n_bad++; $display("FAIL midreset_pre: got %0d expected 5", bit_cnt); end
        #2 reset = 1'b1;
        #1;  // well before the next rising edge
        n_cmp++; if (data_out !== 1'b1) begin n_bad++; $display("FAIL midreset_data_out: got %b expected 1", data_out); end
        n_cmp++; if (bit_cnt !== 4'd0) begin n_bad++; $display("FAIL midreset_bit_cnt: got %0d expected 0", bit_cnt); end
        n_cmp++; if (poll_count !== 16'd0) begin n_bad++; $display("FAIL midreset_count: got %0d expected 0", poll_count); end
        wait_clks(2);
        reset = 1'b0;
        wait_clks(3);
        do_pulse();  // without a latch, pulses must not shift
        n_cmp++; if (bit_cnt !== 4'd0) begin n_bad++; $display("FAIL midreset_no_latch: got %0d expected 0", bit_cnt); end
    endtask

    task automatic test_turbo();
        logic [5:0] exp_a;
`ifdef N8_TURBO_EN
        exp_a = 6'b110011;  // polls 0..5 read 1,1,0,0,1,1
`else
        exp_a = 6'b111111;
`endif
        buttons = 8'h00;
        turbo_a = 1'b1;
        for (int p = 0; p < 6; p++) begin
            do_latch(10);
            n_cmp++;
            if (data_out !== exp_a[p]) begin
                n_bad++; $display("FAIL turbo_poll%0d: got %b expected %b", p, data_out, exp_a[p]);
            end
        end
        turbo_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_a5_overrun();
        test_abort();
        test_capture_at_fall();
        test_reset_mid_poll();
        test_turbo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
